instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder/controller in the 12-bit teaching CPU.
- Holds the program counter and reads a synchronous instruction ROM.
- Latches the fetched word into an instruction register and presents it to the controller with a one-cycle `instr_valid` qualifier.
- Supports free-run, single-step and direct switch-entered (external) instructions; halts on the HALT opcode.

Parameters:
- INSTR_W, 12, instruction width; opcode is bits [INSTR_W-1:INSTR_W-3].
- PC_W, 4, program counter width; ROM depth is 2**PC_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; while high, fetch/issue continuously.
- step  input  1  single-cycle pulse; fetch and issue exactly one instruction.
- ext_load  input  1  single-cycle pulse; issue `ext_instr` instead of ROM data.
- ext_instr  input  INSTR_W  switch-entered instruction.
- imem_addr  output  PC_W  ROM address; combinationally equals `pc`.
- imem_data  input  INSTR_W  ROM read data, valid one cycle after the address is presented.
- instruction  output  INSTR_W  instruction register; feeds the controller.
- instr_valid  output  1  high exactly during the ISSUE cycle.
- pc  output  PC_W  current program counter.
- halted  output  1  high while in HALT.
- busy  output  1  high in REQ, LATCH and ISSUE.

Behaviour:
- Reset (sync, any state, priority over everything):
  - state=IDLE, pc=0, instruction=0, instr_valid=0, halted=0, busy=0.
  - An in-flight fetch is discarded; no `instr_valid` is produced for it.
- States: IDLE, REQ, LATCH, ISSUE, HALT.
- IDLE, priority ext_load > step > run:
  - ext_load: IR<=ext_instr, src_ext<=1, next ISSUE.
  - step or run: src_ext<=0, next REQ.
  - Otherwise stay in IDLE.
- REQ: imem_addr=pc is presented to the ROM; next LATCH.
- LATCH: IR<=imem_data at the end of the cycle; next ISSUE.
- ISSUE: `instr_valid`=1 and `instruction`=IR.
  - At the end of the cycle:
    - If opcode==OP_HALT (3'b111): next HALT, pc unchanged.
    - Else if src_ext==0: pc<=pc+1. pc wraps modulo 2**PC_W, so 4'hF -> 4'h0.
    - Else pc unchanged.
  - Next state: REQ if run==1, else IDLE.
- HALT: `halted`=1. run, step and ext_load are ignored; the only exit is reset.
- Latency:
  - Step pulse sampled at edge N gives REQ in cycle N+1, LATCH in N+2, ISSUE in N+3.
  - ext_load sampled at edge N gives ISSUE in cycle N+1.
  - Run throughput is one instruction per 3 cycles.
- step and ext_load pulses arriving outside IDLE are dropped, not queued.
- run deasserted mid-fetch: the current fetch completes and issues, then the unit returns to IDLE.
- `instruction` holds its last value outside ISSUE. Downstream must gate its register-file write enable and data-memory read/write strobes with `instr_valid`.
- Unknown opcodes (010, 011, 100) are passed through unmodified; they are handled downstream.
- A HALT opcode entered via ext_load also enters HALT.

Decomposition:
- Shared package `cpu_pkg`:
  - INSTR_W.
  - Opcode constants: OP_LOAD=3'b000, OP_STORE=3'b001, OP_ADD=3'b101, OP_SUB=3'b110, OP_HALT=3'b111.
  - Enum `fetch_state_t` {IDLE, REQ, LATCH, ISSUE, HALT}.
- One sub-module, `pc_counter`: PC_W-bit register with sync clear and increment enable, wrapping.
- FSM and instruction register stay in the top module.

Test Plan:
- Reset then step: ROM[0]=12'hA1F, single step pulse -> `instr_valid` high exactly 3 cycles after the pulse edge, instruction=12'hA1F, pc 0->1 after ISSUE, then IDLE.
- Run through wrap: ROM all 12'h000 (load), run=1 for 50 cycles -> `instr_valid` every 3rd cycle, pc sequence 0..F,0,1…, no gaps or duplicates.
- External issue: in IDLE with pc=5, ext_load with ext_instr=12'hC4A -> next cycle instr_valid=1, instruction=12'hC4A, pc stays 5; a simultaneous step is ignored.
- Halt: ROM[0]=12'h200, ROM[1]=12'hE00, run=1 -> two issues, then halted=1 with pc=1; later step, run and ext_load produce no `instr_valid`; reset clears halted, pc=0.
- Reset mid-fetch: step, then reset asserted in the LATCH cycle -> no `instr_valid` pulse, instruction=0, pc=0, state IDLE.
- Dropped pulse: step during REQ of a prior step -> exactly one ISSUE, pc advances by 1 only.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 12-bit teaching CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 12;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LATCH = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Control, ROM and controller-side signals of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int INSTR_W = 12,
    parameter int PC_W    = 4
);
    logic               run;
    logic               step;
    logic               ext_load;
    logic [INSTR_W-1:0] ext_instr;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               halted;
    logic               busy;

    // master: the environment (switches, ROM, controller)
    modport master (
        output run, step, ext_load, ext_instr, imem_data,
        input  imem_addr, instruction, instr_valid, pc, halted, busy
    );

    // slave: the fetch unit itself
    modport slave (
        input  run, step, ext_load, ext_instr, imem_data,
        output imem_addr, instruction, instr_valid, pc, halted, busy
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_counter
// Description : Wrapping program counter with sync clear and increment enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_counter #(
    parameter int PC_W = 4
) (
    input  wire logic            clk,
    input  wire logic            clr,
    input  wire logic            inc,
    output logic      [PC_W-1:0] pc
);
    logic [PC_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc <= '0;
        end else if (inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign pc = r_pc;
endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC, synchronous ROM fetch FSM and instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int PC_W    = 4
) (
    input wire logic     clk,
    input wire logic     reset,
    instr_fetch_if.slave bus
);
    import cpu_pkg::*;

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_src_ext;
    logic               r_valid;
    logic               r_halted;
    logic               r_busy;
    logic [PC_W-1:0]    w_pc;
    logic               w_is_halt;
    logic               w_pc_inc;

    assign w_is_halt = (r_ir[INSTR_W-1 -: 3] == OP_HALT);
    // Only ROM-sourced, non-HALT instructions advance the PC.
    assign w_pc_inc  = (r_state == ISSUE) && !w_is_halt && !r_src_ext;

    pc_counter #(.PC_W(PC_W)) u_pc_counter (
        .clk (clk),
        .clr (reset),
        .inc (w_pc_inc),
        .pc  (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_src_ext <= 1'b0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ext_load) begin
                        r_ir      <= bus.ext_instr;
                        r_src_ext <= 1'b1;
                        r_state   <= ISSUE;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (bus.step || bus.run) begin
                        r_src_ext <= 1'b0;
                        r_state   <= REQ;
                        r_busy    <= 1'b1;
                    end
                end
                REQ: begin
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_ir    <= bus.imem_data;
                    r_state <= ISSUE;
                    r_valid <= 1'b1;
                end
                ISSUE: begin
                    r_valid <= 1'b0;
                    if (w_is_halt) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (bus.run) begin
                        r_src_ext <= 1'b0;
                        r_state   <= REQ;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr   = w_pc;
    assign bus.pc          = w_pc;
    assign bus.instruction = r_ir;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;
    assign bus.busy        = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit with a synchronous ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int INSTR_W = 12;
    localparam int PC_W    = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [INSTR_W-1:0] rom [16];
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

    instr_fetch_unit #(.INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    // Every issue is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got instr=%h pc=%h, expected no issue",
                         bus.instruction, bus.pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.instruction !== e.instr || bus.pc !== e.pc) begin
                    n_err++;
                    $display("FAIL issue_content: got instr=%h pc=%h, expected instr=%h pc=%h",
                             bus.instruction, bus.pc, e.instr, e.pc);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.run = 1'b0; bus.step = 1'b0; bus.ext_load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Single step from IDLE, expecting the ROM word at the current pc.
    task automatic pulse_step(input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] pc);
        exp_q.push_back('{instr: instr, pc: pc});
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ext_instr = '0;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        do_reset();
        n_cmp++;
        if (bus.instruction !== 12'h000 || bus.pc !== 4'h0 || bus.instr_valid !== 1'b0 ||
            bus.halted !== 1'b0 || bus.busy !== 1'b0 || bus.imem_addr !== 4'h0) begin
            n_err++;
            $display("FAIL reset_state: got instr=%h pc=%h v=%b h=%b busy=%b addr=%h, expected all zero",
                     bus.instruction, bus.pc, bus.instr_valid, bus.halted, bus.busy, bus.imem_addr);
        end
    endtask

    task automatic test_step();
        rom[0] = 12'hA1F;
        do_reset();
        exp_q.push_back('{instr: 12'hA1F, pc: 4'h0});
        bus.step = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.step = 1'b0;
            n_cmp++;
            if (bus.instr_valid !== (i == 3)) begin
                n_err++;
                $display("FAIL step_latency: cycle %0d got valid=%b, expected %b", i, bus.instr_valid, i == 3);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.pc !== 4'h1 || bus.busy !== 1'b0 || bus.instruction !== 12'hA1F) begin
            n_err++;
            $display("FAIL step_after: got pc=%h busy=%b instr=%h, expected pc=1 busy=0 instr=a1f",
                     bus.pc, bus.busy, bus.instruction);
        end
    endtask

    task automatic test_run_wrap();
        for (int i = 0; i < 16; i++) rom[i] = '0;
        do_reset();
        for (int i = 0; i < 17; i++) exp_q.push_back('{instr: 12'h000, pc: 4'(i)});
        bus.run = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.instr_valid !== (i % 3 == 0)) begin
                n_err++;
                $display("FAIL run_cadence: cycle %0d got valid=%b, expected %b", i, bus.instr_valid, i % 3 == 0);
            end
        end
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || bus.pc !== 4'h1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL run_wrap_end: got pending=%0d pc=%h busy=%b, expected pending=0 pc=1 busy=0",
                     exp_q.size(), bus.pc, bus.busy);
        end
    endtask

    task automatic test_ext();
        for (int i = 0; i < 16; i++) rom[i] = '0;
        do_reset();
        for (int i = 0; i < 5; i++) pulse_step(12'h000, 4'(i));
        n_cmp++;
        if (bus.pc !== 4'h5) begin
            n_err++;
            $display("FAIL ext_setup_pc: got pc=%h, expected 5", bus.pc);
        end
        exp_q.push_back('{instr: 12'hC4A, pc: 4'h5});
        bus.ext_instr = 12'hC4A;
        bus.ext_load  = 1'b1;
        bus.step      = 1'b1;
        @(negedge clk);
        bus.ext_load = 1'b0;
        bus.step     = 1'b0;
        n_cmp++;
        if (bus.instr_valid !== 1'b1 || bus.instruction !== 12'hC4A) begin
            n_err++;
            $display("FAIL ext_issue: got valid=%b instr=%h, expected valid=1 instr=c4a",
                     bus.instr_valid, bus.instruction);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (bus.pc !== 4'h5 || bus.busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ext_after: got pc=%h busy=%b pending=%0d, expected pc=5 busy=0 pending=0",
                     bus.pc, bus.busy, exp_q.size());
        end
    endtask

    task automatic test_halt();
        int cyc;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 12'h200;
        rom[1] = 12'hE00;
        do_reset();
        exp_q.push_back('{instr: 12'h200, pc: 4'h0});
        exp_q.push_back('{instr: 12'hE00, pc: 4'h1});
        bus.run = 1'b1;
        cyc = 0;
        while (bus.halted !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.pc !== 4'h1 || bus.busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL halt_enter: got halted=%b pc=%h busy=%b pending=%0d, expected 1/1/0/0",
                     bus.halted, bus.pc, bus.busy, exp_q.size());
        end
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        bus.ext_instr = 12'h123;
        bus.ext_load = 1'b1;
        @(negedge clk);
        bus.ext_load = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.pc !== 4'h1) begin
            n_err++;
            $display("FAIL halt_hold: got halted=%b pc=%h, expected halted=1 pc=1", bus.halted, bus.pc);
        end
        do_reset();
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.pc !== 4'h0) begin
            n_err++;
            $display("FAIL halt_reset: got halted=%b pc=%h, expected halted=0 pc=0", bus.halted, bus.pc);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 12'hA1F;
        rom[1] = 12'h5B3;
        do_reset();
        pulse_step(12'hA1F, 4'h0);
        n_cmp++;
        if (bus.instruction !== 12'hA1F || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ir_hold: got instr=%h valid=%b, expected instr=a1f valid=0",
                     bus.instruction, bus.instr_valid);
        end
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (bus.instruction !== 12'h000 || bus.pc !== 4'h0 || bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got instr=%h pc=%h busy=%b valid=%b, expected all zero",
                     bus.instruction, bus.pc, bus.busy, bus.instr_valid);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_dropped_pulse();
        for (int i = 0; i < 16; i++) rom[i] = '0;
        do_reset();
        exp_q.push_back('{instr: 12'h000, pc: 4'h0});
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (bus.pc !== 4'h1 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL dropped_pulse: got pc=%h pending=%0d busy=%b, expected pc=1 pending=0 busy=0",
                     bus.pc, exp_q.size(), bus.busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.step = 1'b0; bus.ext_load = 1'b0; bus.ext_instr = '0;
        test_reset();
        test_step();
        test_run_wrap();
        test_ext();
        test_halt();
        test_reset_mid();
        test_dropped_pulse();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_pending: got %0d outstanding issues, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
